// File: rtl/dmem_responder.sv
// Memory-side responder for the rv32i data port: word array with byte-lane
// writes, a fixed request-to-response latency, and range/protocol error flags.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        proto_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_q, resp_d;
  logic        err_q, err_d;
  logic        proto_q, proto_d;

  logic [31:0] mem_q [DEPTH];
  logic        mem_we;
  logic        in_range;
  logic [ADDR_W-1:0] idx;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  assign unused_addr_bits = ^mem_address[1:0];
  assign in_range = (addr_q[31:ADDR_W+2] == '0);
  assign idx      = addr_q[ADDR_W+1:2];

  // RESP is the final internal cycle; the outputs it computes are registered,
  // so the visible pulse lands one cycle later while the FSM is already IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rdata_d = '0;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    proto_d = proto_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          wr_d    = mem_write;
          cnt_d   = 4'(LATENCY - 1);
          proto_d = proto_q | (mem_read & mem_write);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        resp_d  = 1'b1;
        err_d   = ~in_range;
        mem_we  = rst & wr_q & in_range;
        if (!wr_q && in_range) rdata_d = mem_q[idx];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      proto_q <= proto_d;
    end
  end

  // Request payload only matters while the FSM is busy, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    wr_q    <= wr_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merge_lanes(mem_q[idx], wdata_q, be_q);
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;
  assign mem_err   = err_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, latency corner
// sequences at LATENCY 1/2/4, and randomized traffic against a word-array model.
module tb_dmem_responder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        resp  [3];
  logic        err   [3];
  logic        perr  [3];

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .mem_address(addr[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_resp(resp[0]), .mem_err(err[0]), .proto_err(perr[0]));
  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_address(addr[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_resp(resp[1]), .mem_err(err[1]), .proto_err(perr[1]));
  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(4)) u2 (
    .clk(clk), .rst(rst), .mem_address(addr[2]), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_byte_enable(be[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]),
    .mem_resp(resp[2]), .mem_err(err[2]), .proto_err(perr[2]));

  int checks = 0;
  int errors = 0;

  // Transaction-level model of unit 0: a plain word array plus the sticky flag.
  logic [31:0] model_mem [DEPTH];
  bit          model_proto = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  task automatic model_txn(input bit r, input bit w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d,
                           output logic [31:0] exp_rd, output bit exp_err);
    bit ok;
    int w_idx;
    ok      = (a >> (ADDR_W + 2)) == 0;
    w_idx   = int'((a >> 2) % DEPTH);
    exp_err = !ok;
    exp_rd  = '0;
    if (r && w) model_proto = 1'b1;
    if (w) begin
      if (ok) model_mem[w_idx] = (model_mem[w_idx] & ~lane_mask(b)) | (d & lane_mask(b));
    end else if (ok) begin
      exp_rd = model_mem[w_idx];
    end
  endtask

  // Drives one request on unit u and holds it until mem_resp is seen.
  task automatic txn(input int u, input bit r, input bit w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     output int lat, output logic [31:0] rd_out,
                     output logic err_out, output logic perr_out);
    lat = -1; rd_out = '0; err_out = 1'b0; perr_out = 1'b0;
    @(posedge clk); #1;
    addr[u] = a; rd[u] = r; wr[u] = w; be[u] = b; wdata[u] = d;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (resp[u]) begin
        lat = k - 1; rd_out = rdata[u]; err_out = err[u]; perr_out = perr[u];
        break;
      end
      check("rdata_zero_outside_resp", rdata[u], 32'h0);
    end
    rd[u] = 1'b0; wr[u] = 1'b0;
    @(negedge clk);
    check("resp_single_cycle", {31'b0, resp[u]}, 32'h0);
    check("rdata_zero_after_resp", rdata[u], 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 3; u++) begin
      check({tag, "_resp"},  {31'b0, resp[u]}, 32'h0);
      check({tag, "_rdata"}, rdata[u], 32'h0);
      check({tag, "_err"},   {31'b0, err[u]}, 32'h0);
      check({tag, "_perr"},  {31'b0, perr[u]}, 32'h0);
    end
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          exp_perr;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [$];
    int          lat;
    logic [31:0] got_rd, exp_rd;
    logic        got_err, got_perr;
    bit          exp_err;
    int          resp_k;
    logic [31:0] resp_data;

    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      addr[u] = '0; rd[u] = 1'b0; wr[u] = 1'b0; be[u] = '0; wdata[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    tbl.push_back('{0, 1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        0, 0});
    tbl.push_back('{1, 0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF, 0, 0});
    tbl.push_back('{0, 1, 32'h20,  4'hF, 32'h11223344, 32'h0,        0, 0});
    tbl.push_back('{0, 1, 32'h20,  4'h5, 32'hAABBCCDD, 32'h0,        0, 0});
    tbl.push_back('{1, 0, 32'h20,  4'h0, 32'h0,        32'h11BB33DD, 0, 0});
    tbl.push_back('{0, 1, 32'h0,   4'hF, 32'h01020304, 32'h0,        0, 0});
    tbl.push_back('{1, 0, 32'h400, 4'h0, 32'h0,        32'h0,        1, 0});
    tbl.push_back('{0, 1, 32'h400, 4'hF, 32'hFFFFFFFF, 32'h0,        1, 0});
    tbl.push_back('{1, 0, 32'h0,   4'h0, 32'h0,        32'h01020304, 0, 0});
    tbl.push_back('{0, 1, 32'h30,  4'hF, 32'h0BADF00D, 32'h0,        0, 0});
    tbl.push_back('{0, 1, 32'h30,  4'h0, 32'hFFFFFFFF, 32'h0,        0, 0});
    tbl.push_back('{1, 0, 32'h32,  4'h0, 32'h0,        32'h0BADF00D, 0, 0});
    tbl.push_back('{1, 1, 32'h8,   4'hF, 32'h5,        32'h0,        0, 1});
    tbl.push_back('{1, 0, 32'h8,   4'h0, 32'h0,        32'h5,        0, 1});
    tbl.push_back('{1, 0, 32'h13,  4'h0, 32'h0,        32'hDEADBEEF, 0, 1});

    foreach (tbl[i]) begin
      txn(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, lat, got_rd, got_err, got_perr);
      model_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, exp_rd, exp_err);
      check($sformatf("tbl%0d_latency", i), lat, 2);
      check($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), {31'b0, got_err}, {31'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d_perr", i), {31'b0, got_perr}, {31'b0, tbl[i].exp_perr});
    end

    // Reset while a write sits in WAIT: it must vanish without a response.
    @(posedge clk); #1;
    addr[0] = 32'h8; wr[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'h77;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; wr[0] = 1'b0;
    check_reset_state("midwait_reset");
    model_proto = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midwait_no_resp", {31'b0, resp[0]}, 32'h0);
    end
    txn(0, 1, 0, 32'h8, 4'h0, 32'h0, lat, got_rd, got_err, got_perr);
    check("midwait_word_kept", got_rd, 32'h5);
    check("midwait_perr_clear", {31'b0, got_perr}, 32'h0);

    // LATENCY=1: write then continuously held read gives a pulse every other cycle.
    txn(1, 0, 1, 32'h4, 4'hF, 32'hCAFEF00D, lat, got_rd, got_err, got_perr);
    check("lat1_write_latency", lat, 1);
    @(posedge clk); #1;
    addr[1] = 32'h4; rd[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("lat1_b2b_resp%0d", k), {31'b0, resp[1]}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("lat1_b2b_rdata%0d", k), rdata[1], (k % 2 == 0) ? 32'hCAFEF00D : 32'h0);
    end
    rd[1] = 1'b0;
    @(negedge clk);

    // LATENCY=4: request dropped and address changed during WAIT.
    txn(2, 0, 1, 32'h8, 4'hF, 32'h13572468, lat, got_rd, got_err, got_perr);
    check("lat4_write_latency", lat, 4);
    @(posedge clk); #1;
    addr[2] = 32'h8; rd[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rd[2] = 1'b0; addr[2] = 32'h40;
    resp_k = -1; resp_data = '0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (resp[2] && resp_k < 0) begin
        resp_k = k; resp_data = rdata[2];
      end
    end
    check("lat4_drop_latency", resp_k - 1, 4);
    check("lat4_drop_rdata", resp_data, 32'h13572468);

    // Give the model a fully known array before random traffic.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom();
      txn(0, 0, 1, 32'(i) << 2, 4'hF, d, lat, got_rd, got_err, got_perr);
      model_txn(0, 1, 32'(i) << 2, 4'hF, d, exp_rd, exp_err);
      if (lat != 2) check("fill_latency", lat, 2);
    end
    check("fill_done_perr", {31'b0, perr[0]}, 32'h0);

    for (int n = 0; n < 300; n++) begin
      int          sel;
      bit          r, w;
      logic [31:0] a, d;
      logic [3:0]  b;
      sel = $urandom_range(0, 9);
      r = (sel <= 4) || (sel == 9);
      w = (sel >= 5);
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h400;
      else a = 32'($urandom_range(0, 1023));
      b = 4'($urandom_range(0, 15));
      d = $urandom();
      txn(0, r, w, a, b, d, lat, got_rd, got_err, got_perr);
      model_txn(r, w, a, b, d, exp_rd, exp_err);
      check($sformatf("rnd%0d_latency", n), lat, 2);
      check($sformatf("rnd%0d_rdata", n), got_rd, exp_rd);
      check($sformatf("rnd%0d_err", n), {31'b0, got_err}, {31'b0, exp_err});
      check($sformatf("rnd%0d_perr", n), {31'b0, got_perr}, {31'b0, model_proto});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the rv32i pipeline data port; the slave end of the mem_read/mem_write/mem_resp handshake the datapath initiates.
- Backs a word-addressed internal array with per-byte write enables and a fixed, parameterised response latency.
- Stands in for the data cache/physical memory in unit and core-level benches.
- Reports out-of-range and protocol errors.

Parameters:
ADDR_W, 8, log2 of array depth in 32-bit words (DEPTH = 2^ADDR_W)
LATENCY, 2, cycles from request acceptance to mem_resp; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0)
mem_address  input  32  byte address; bits [1:0] ignored (word access)
mem_read  input  1  read request; held by requester until mem_resp
mem_write  input  1  write request; held by requester until mem_resp
mem_byte_enable  input  4  write byte mask; bit i enables byte lane i, i.e. bits [8i+7:8i]
mem_wdata  input  32  write data
mem_rdata  output  32  read data; valid only while mem_resp=1, 0 otherwise
mem_resp  output  1  one-cycle completion pulse
mem_err  output  1  pulses with mem_resp when the access was out of range
proto_err  output  1  sticky; set when read and write are sampled high together

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; mem_resp, mem_rdata, mem_err and proto_err all become 0.
  - Array contents are not cleared.
  - Reset during WAIT or RESP aborts the transaction; a pending write is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high at edge T, latch address, op, byte_enable and wdata.
  - Load the counter with LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - Move to RESP when the counter reaches 1 on the current edge.
  - Net timing: mem_resp is high during the cycle beginning at edge T+LATENCY.
  - Input changes during WAIT are ignored; latched values are used throughout.
- RESP:
  - mem_resp=1 for exactly one cycle, then return to IDLE.
  - No new request is accepted in the RESP cycle.
  - The requester deasserts in the cycle following mem_resp. Earliest next acceptance is edge T+LATENCY+1.
- Read: mem_rdata is registered on entry to RESP with array[addr[ADDR_W+1:2]]. Outside RESP, mem_rdata=0.
- Write:
  - The array is updated at the edge entering RESP, only on lanes where byte_enable=1.
  - mem_rdata=0 during a write response.
  - byte_enable=0000 still completes with mem_resp and leaves the array unchanged.
- Read-after-write to the same word returns the new data, since the write commits before any later acceptance.
- Out of range is defined as latched address[31:ADDR_W+2] != 0:
  - The write is dropped.
  - Read data is 0.
  - mem_err=1 in the RESP cycle.
- Read and write both high at acceptance:
  - The access is treated as a write.
  - proto_err is set and stays set until reset.

Test Plan:
- Reset, write 0xDEADBEEF to 0x10 with byte_enable=1111, then read 0x10 -> mem_resp at T+2 for each access; read mem_rdata=0xDEADBEEF; mem_rdata=0 in all other cycles.
- Word at 0x20 holds 0x11223344; write 0xAABBCCDD with byte_enable=0101, then read -> 0x11BB33DD.
- Read 0x400 with ADDR_W=8 -> mem_resp=1, mem_err=1, mem_rdata=0. Write to the same address -> no array change, checked via alias 0x000 unchanged.
- LATENCY=1, back-to-back reads (requester deasserts for one cycle) -> mem_resp on every other cycle; drop mem_read during WAIT at LATENCY=4 -> mem_resp still at T+4.
- mem_read and mem_write both high, address 0x8, data 0x5 -> write performed and proto_err=1 sticky. rst=0 mid-WAIT on a write -> no mem_resp, word at that address unchanged, proto_err=0.
